// File: rtl/vga_timing_pkg.sv
// Timing constants for 640x480@60 Hz on a 25 MHz pixel clock,
// plus the RGB565 palette shared with the picture generator.
package vga_timing_pkg;

    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BACK   = 10'd40;
    localparam logic [9:0] H_LEFT   = 10'd8;
    localparam logic [9:0] H_VALID  = 10'd640;
    localparam logic [9:0] H_RIGHT  = 10'd8;
    localparam logic [9:0] H_FRONT  = 10'd8;
    localparam logic [9:0] H_TOTAL  = 10'd800;

    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BACK   = 10'd25;
    localparam logic [9:0] V_TOP    = 10'd8;
    localparam logic [9:0] V_VALID  = 10'd480;
    localparam logic [9:0] V_BOTTOM = 10'd8;
    localparam logic [9:0] V_FRONT  = 10'd2;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    // Origin and end of the request window, in counter coordinates.
    localparam logic [9:0] HS0    = H_SYNC + H_BACK + H_LEFT;
    localparam logic [9:0] VS0    = V_SYNC + V_BACK + V_TOP;
    localparam logic [9:0] HE0    = HS0 + H_VALID;
    localparam logic [9:0] VE0    = VS0 + V_VALID;
    localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;

    localparam logic [9:0] PIX_NONE = 10'h3FF;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

endpackage

// File: rtl/vga_ctrl.sv
// VGA timing generator: line/frame counters, pixel request coordinates and
// one register stage that aligns sync, valid and colour on the output pins.
module vga_ctrl
    import vga_timing_pkg::*;
(
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_end;
    logic       req;

    assign h_end = (cnt_h == H_LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= 10'd0;
        end else if (h_end) begin
            cnt_h <= 10'd0;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_v <= 10'd0;
        end else if (h_end) begin
            if (cnt_v == V_LAST) begin
                cnt_v <= 10'd0;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end
    end

    assign req = (cnt_h >= HS0) && (cnt_h < HE0) && (cnt_v >= VS0) && (cnt_v < VE0);

    // The picture generator answers combinationally, so pix_data belongs to
    // the coordinates presented in this same cycle.
    assign pix_x = req ? (cnt_h - HS0) : PIX_NONE;
    assign pix_y = req ? (cnt_v - VS0) : PIX_NONE;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            rgb_valid   <= 1'b0;
            rgb         <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (cnt_h < H_SYNC);
            vsync       <= (cnt_v < V_SYNC);
            rgb_valid   <= req;
            rgb         <= req ? pix_data : RGB_BLACK;
            frame_start <= (cnt_h == 10'd0) && (cnt_v == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: vector table over the first visible lines,
// running aggregates, and a reset pulse inside the visible region.
module tb_vga_ctrl;

    logic        vga_clk;
    logic        sys_rst_n;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
    logic        frame_start;

    int checks;
    int errors;
    int pos;
    int phase1;
    int hs_cnt;
    int vs_cnt;
    int rv_cnt;
    int align_err;
    int align_seen;

    vga_ctrl dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb_valid   (rgb_valid),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    // Zero-latency picture generator: colour encodes the requested X.
    assign pix_data = {6'b0, pix_x};

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    typedef struct {
        int          pos;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        hs;
        logic        vs;
        logic        rv;
        logic [15:0] rgb;
        logic        fs;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, pos);
        end
    endtask

    // One clock; pos is the counter value (v*800+h) after the edge.
    task automatic step();
        logic [9:0] px_before;
        px_before = pix_x;
        @(posedge vga_clk);
        pos++;
        @(negedge vga_clk);
        if (phase1 != 0) begin
            if (pos >= 1 && pos <= 800 && hsync) hs_cnt++;
            if (pos >= 1 && pos <= 2400 && vsync) vs_cnt++;
            if (pos >= 28001 && pos <= 28800 && rgb_valid) rv_cnt++;
        end
        if (rgb_valid) begin
            align_seen++;
            if (rgb !== {6'b0, px_before}) align_err++;
        end else if (rgb !== 16'h0) begin
            align_err++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pix_x"}, 32'(pix_x), 32'h3FF);
        chk({tag, "_pix_y"}, 32'(pix_y), 32'h3FF);
        chk({tag, "_hsync"}, 32'(hsync), 32'd0);
        chk({tag, "_vsync"}, 32'(vsync), 32'd0);
        chk({tag, "_rgb_valid"}, 32'(rgb_valid), 32'd0);
        chk({tag, "_rgb"}, 32'(rgb), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        int found;
        checks = 0; errors = 0; pos = 0; phase1 = 1;
        hs_cnt = 0; vs_cnt = 0; rv_cnt = 0; align_err = 0; align_seen = 0;

        //          pos    px       py       hs    vs    rv    rgb       fs
        vecs[0]  = '{1,     10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 16'd0,   1'b1};
        vecs[1]  = '{2,     10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 16'd0,   1'b0};
        vecs[2]  = '{96,    10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 16'd0,   1'b0};
        vecs[3]  = '{97,    10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 16'd0,   1'b0};
        vecs[4]  = '{800,   10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 16'd0,   1'b0};
        vecs[5]  = '{801,   10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 16'd0,   1'b0};
        vecs[6]  = '{1601,  10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 16'd0,   1'b0};
        vecs[7]  = '{27700, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0};
        vecs[8]  = '{28143, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0};
        vecs[9]  = '{28144, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 16'd0,   1'b0};
        vecs[10] = '{28145, 10'd1,   10'd0,   1'b0, 1'b0, 1'b1, 16'd0,   1'b0};
        vecs[11] = '{28146, 10'd2,   10'd0,   1'b0, 1'b0, 1'b1, 16'd1,   1'b0};
        vecs[12] = '{28783, 10'd639, 10'd0,   1'b0, 1'b0, 1'b1, 16'd638, 1'b0};
        vecs[13] = '{28784, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 16'd639, 1'b0};
        vecs[14] = '{28785, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 16'd0,   1'b0};
        vecs[15] = '{29300, 10'd356, 10'd1,   1'b0, 1'b0, 1'b1, 16'd355, 1'b0};

        sys_rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        chk_reset_vals("rst");

        sys_rst_n = 1'b1;
        pos = 0;
        for (int i = 0; i < 16; i++) begin
            while (pos < vecs[i].pos) step();
            chk($sformatf("v%0d_pix_x", i), 32'(pix_x), 32'(vecs[i].px));
            chk($sformatf("v%0d_pix_y", i), 32'(pix_y), 32'(vecs[i].py));
            chk($sformatf("v%0d_hsync", i), 32'(hsync), 32'(vecs[i].hs));
            chk($sformatf("v%0d_vsync", i), 32'(vsync), 32'(vecs[i].vs));
            chk($sformatf("v%0d_rgb_valid", i), 32'(rgb_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d_rgb", i), 32'(rgb), 32'(vecs[i].rgb));
            chk($sformatf("v%0d_frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
        end

        chk("hsync_clocks_line0", 32'(hs_cnt), 32'd96);
        chk("vsync_clocks", 32'(vs_cnt), 32'd1600);
        chk("rgb_valid_clocks_line35", 32'(rv_cnt), 32'd640);
        chk("rgb_align_errors", 32'(align_err), 32'd0);
        chk("rgb_align_seen", 32'(align_seen > 0), 32'd1);

        // Reset pulse at (36, 500), inside the visible region.
        phase1 = 0;
        #1 sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        chk_reset_vals("midrst_hold");
        sys_rst_n = 1'b1;
        pos = 0;
        step();
        chk("post_rst_frame_start", 32'(frame_start), 32'd1);
        chk("post_rst_hsync", 32'(hsync), 32'd1);
        chk("post_rst_vsync", 32'(vsync), 32'd1);
        chk("post_rst_rgb_valid", 32'(rgb_valid), 32'd0);

        found = 0;
        for (int k = 0; k < 40000 && found == 0; k++) begin
            if (rgb_valid) found = 1;
            else step();
        end
        chk("post_rst_valid_found", 32'(found), 32'd1);
        chk("post_rst_valid_latency", 32'(pos), 32'(35 * 800 + 144 + 1));
        chk("post_rst_first_rgb", 32'(rgb), 32'd0);
        chk("post_rst_align_errors", 32'(align_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
